if_fetch_unit: RTL

Instruction-fetch stage of the pipelined MIPS datapath: holds PC/nPC, issues one-outstanding instruction-memory reads, and delivers fetched words to the IF/ID boundary with stall back-pressure. It sits directly upstream of the decode-stage muxes. The branch delay slot is honoured by applying redirects to nPC, never to an instruction already issued. Next-address selection uses the datapath 4:1 32-bit mux.

---
 rtl/if_pkg.sv | 21 ++
 rtl/if_fetch_unit_mux.sv | 21 ++
 rtl/if_fetch_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: fetch FSM state,
// next-address select encodings and instruction size.
package if_pkg;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } fetch_state_e;

    localparam logic [1:0] SEL_SEQ    = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_JUMP   = 2'b10;
    localparam logic [1:0] SEL_REG    = 2'b11;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/if_fetch_unit_mux.sv
// Datapath 4:1 32-bit mux, used here for next-nPC selection.
module Mux_4x1_32b (
    input  logic [31:0] in_0,
    input  logic [31:0] in_1,
    input  logic [31:0] in_2,
    input  logic [31:0] in_3,
    input  logic [1:0]  select,
    output logic [31:0] out
);

    always_comb begin
        out = in_0;
        case (select)
            2'b00:   out = in_0;
            2'b01:   out = in_1;
            2'b10:   out = in_2;
            default: out = in_3;
        endcase
    end

endmodule

// File: rtl/if_fetch_unit.sv
// MIPS instruction-fetch stage: PC/nPC with delay-slot semantics, one
// outstanding imem read, and a one-entry skid behind the IF/ID register.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic [1:0]  redirect_sel,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] reg_target,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc
);
    import if_pkg::*;

    fetch_state_e state;
    logic [31:0]  pc, npc;
    logic [31:0]  skid_instr, skid_pc;

    logic        consume, slot_free, redirect;
    logic [1:0]  mux_sel;
    logic [31:0] npc_seq, next_npc, target_seq;

    assign consume   = ifid_valid & ~stall;
    assign slot_free = ~ifid_valid | ~stall;
    // Redirects only count on the cycle decode actually takes the branch.
    assign redirect  = consume & (redirect_sel != SEL_SEQ);
    assign mux_sel   = consume ? redirect_sel : SEL_SEQ;

    assign npc_seq    = npc + INSTR_BYTES;
    assign target_seq = next_npc + INSTR_BYTES;

    Mux_4x1_32b u_npc_mux (
        .in_0   (npc_seq),
        .in_1   (word_align(branch_target)),
        .in_2   (word_align(jump_target)),
        .in_3   (word_align(reg_target)),
        .select (mux_sel),
        .out    (next_npc)
    );

    assign imem_req  = (state == ST_FETCH) & ~reset;
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_PC;
            npc        <= RESET_PC + INSTR_BYTES;
            state      <= ST_FETCH;
            skid_instr <= '0;
            skid_pc    <= '0;
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
            ifid_pc    <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ready) begin
                        if (slot_free) begin
                            ifid_instr <= imem_rdata;
                            ifid_pc    <= pc;
                            ifid_valid <= 1'b1;
                        end else begin
                            skid_instr <= imem_rdata;
                            skid_pc    <= pc;
                            state      <= ST_HOLD;
                        end
                        // The word just accepted is the delay slot of a redirecting branch.
                        if (redirect) begin
                            pc  <= next_npc;
                            npc <= target_seq;
                        end else begin
                            pc  <= npc;
                            npc <= next_npc;
                        end
                    end else begin
                        if (consume)
                            ifid_valid <= 1'b0;
                        // Delay slot still pending at pc: only nPC moves.
                        if (redirect)
                            npc <= next_npc;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        ifid_instr <= skid_instr;
                        ifid_pc    <= skid_pc;
                        ifid_valid <= 1'b1;
                        state      <= ST_FETCH;
                        if (redirect) begin
                            pc  <= next_npc;
                            npc <= target_seq;
                        end
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule
